ysyx_22050598_mem_arbiter: RTL and testbench
============================================

YSYX_22050598_MEM_ARBITER -- requirements
Module: ysyx_22050598_mem_arbiter

Interface
REQ-001 Parameter AW, 64, address width.
REQ-002 Parameter DW, 64, data width.
REQ-003 Parameter STARVE_MAX, 4, max consecutive LSU grants while IFU waits.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset (asserted when 0).
REQ-006 if_req_valid in 1 / if_req_addr in AW / if_req_ready out 1  IFU read request handshake.
REQ-007 if_rsp_valid out 1 / if_rsp_data out DW  IFU read response.
REQ-008 ls_req_valid in 1 / ls_req_wen in 1 / ls_req_addr in AW / ls_req_wdata in DW / ls_req_wmask in DW/8 / ls_req_ready out 1  LSU request handshake.
REQ-009 ls_rsp_valid out 1 / ls_rsp_data out DW  LSU response; also issued for writes as write-ack.
REQ-010 mem_req_valid out 1 / mem_req_ready in 1 / mem_req_wen out 1 / mem_req_addr out AW / mem_req_wdata out DW / mem_req_wmask out DW/8  shared memory port request.
REQ-011 mem_rsp_valid in 1 / mem_rsp_data in DW  memory response.
REQ-012 busy  out 1  high whenever state is not IDLE.

Function
REQ-013 FSM states IDLE, REQ, WAIT; at most one transaction outstanding.
REQ-014 IDLE: grant chosen combinationally. If only one requester is valid, it wins. If both are valid, LSU wins unless starve_cnt == STARVE_MAX, in which case IFU wins.
REQ-015 In IDLE, if_req_ready / ls_req_ready are high only for the granted requester; both are low in REQ and WAIT.
REQ-016 On accept: latch owner, wen (0 for IFU), addr with [2:0] forced to 0, wdata, and wmask (0 for IFU); then IDLE->REQ.
REQ-017 REQ: mem_req_valid=1 with latched fields held stable until mem_req_ready=1; then REQ->WAIT.
REQ-018 WAIT: on mem_rsp_valid=1, assert owner's rsp_valid in that same cycle with rsp_data=mem_rsp_data; then WAIT->IDLE.
REQ-019 Minimum occupancy is 3 cycles (accept, request, response); a new accept is possible in the cycle after the response.
REQ-020 mem_rsp_valid outside WAIT is ignored; no rsp_valid is produced.
REQ-021 The memory contract forbids mem_rsp_valid in the same cycle as the mem_req handshake; the arbiter samples responses only in WAIT.
REQ-022 starve_cnt (width clog2(STARVE_MAX+1)): +1 on an LSU grant while if_req_valid=1, saturating at STARVE_MAX; cleared on any IFU grant; unchanged otherwise.
REQ-023 rsp_valid of the non-owner is always 0; rsp_data is 0 whenever rsp_valid is 0.
REQ-024 Requester valid deasserted before accept: no grant and no state change.

Reset
REQ-025 With rst=0 at a clock edge: state=IDLE, starve_cnt=0, latched fields=0.
REQ-026 During and after reset: all *_valid, *_ready and busy outputs are 0 until the first cycle after release.
REQ-027 Reset mid-transaction abandons it: no rsp is emitted, and a late mem_rsp_valid is ignored per REQ-020.

Structure
REQ-028 Package ysyx_22050598_mem_pkg SHALL hold the state enum (IDLE/REQ/WAIT), the owner enum (OWN_IF/OWN_LS), and the AW/DW defaults.
REQ-029 Grant logic SHALL be in sub-module ysyx_22050598_mem_arb_pick (inputs: two valids and starve_cnt; output: one-hot grant).

Verification
REQ-030 IFU-only read of 0x8000_0004, mem_req_ready=1 immediately, response 2 cycles later with 0x1122334455667788 -> mem_req_addr=0x8000_0000; if_rsp_valid for 1 cycle with that data.
REQ-031 Both valid from reset; LSU issues 6 back-to-back reads -> grants are LSU×4, then IFU, then LSU; starve_cnt returns to 0 after the IFU grant.
REQ-032 LSU write (addr 0x8000_0010, wdata 0xDEAD, wmask 0x03), mem_req_ready low for 3 cycles -> mem_req fields stable for 4 cycles; ls_rsp_valid pulses once on mem_rsp_valid.
REQ-033 rst=0 asserted while in WAIT, mem_rsp_valid arrives 1 cycle after release -> no if_rsp_valid or ls_rsp_valid; state=IDLE.
REQ-034 Spurious mem_rsp_valid in IDLE -> no rsp outputs, state unchanged; a following IFU request completes normally.

Source files
------------

// File: rtl/ysyx_22050598_mem_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
package ysyx_22050598_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int unsigned AW_DEFAULT = 64;
  localparam int unsigned DW_DEFAULT = 64;

  // Bit positions inside the one-hot grant vector.
  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_LS = 1;

endpackage

// File: rtl/ysyx_22050598_mem_arb_pick.sv
// Grant selection: LSU priority with an anti-starvation override for the IFU.
module ysyx_22050598_mem_arb_pick
  import ysyx_22050598_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CW         = 3
) (
  input  logic          if_valid,
  input  logic          ls_valid,
  input  logic [CW-1:0] starve_cnt,
  output logic [1:0]    grant
);

  always_comb begin
    grant = '0;
    if (if_valid && ls_valid) begin
      if (starve_cnt == CW'(STARVE_MAX)) grant[GNT_IF] = 1'b1;
      else                               grant[GNT_LS] = 1'b1;
    end else if (if_valid) begin
      grant[GNT_IF] = 1'b1;
    end else if (ls_valid) begin
      grant[GNT_LS] = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22050598_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port, one transaction in flight.
module ysyx_22050598_mem_arbiter
  import ysyx_22050598_mem_pkg::*;
#(
  parameter int unsigned AW         = AW_DEFAULT,
  parameter int unsigned DW         = DW_DEFAULT,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req_valid,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_req_ready,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,

  input  logic            ls_req_valid,
  input  logic            ls_req_wen,
  input  logic [AW-1:0]   ls_req_addr,
  input  logic [DW-1:0]   ls_req_wdata,
  input  logic [DW/8-1:0] ls_req_wmask,
  output logic            ls_req_ready,
  output logic            ls_rsp_valid,
  output logic [DW-1:0]   ls_rsp_data,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data,

  output logic            busy
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  state_t            state, state_next;
  owner_t            owner;
  logic              wen_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wmask_q;
  logic [CW-1:0]     starve_cnt;
  logic [1:0]        grant;
  logic              accept;

  ysyx_22050598_mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX),
    .CW        (CW)
  ) u_pick (
    .if_valid  (if_req_valid),
    .ls_valid  (ls_req_valid),
    .starve_cnt(starve_cnt),
    .grant     (grant)
  );

  assign accept = (state == IDLE) && (|grant);

  // Handshake outputs are gated by rst so nothing is visible while reset is held.
  always_comb begin
    state_next    = state;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    if_rsp_data   = '0;
    ls_rsp_valid  = 1'b0;
    ls_rsp_data   = '0;
    case (state)
      IDLE: begin
        if_req_ready = rst && grant[GNT_IF];
        ls_req_ready = rst && grant[GNT_LS];
        if (|grant) state_next = REQ;
      end
      REQ: begin
        mem_req_valid = rst;
        if (mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_next = IDLE;
          if (rst) begin
            if (owner == OWN_IF) begin
              if_rsp_valid = 1'b1;
              if_rsp_data  = mem_rsp_data;
            end else begin
              ls_rsp_valid = 1'b1;
              ls_rsp_data  = mem_rsp_data;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy          = rst && (state != IDLE);
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (grant[GNT_IF]) begin
          owner      <= OWN_IF;
          wen_q      <= 1'b0;
          addr_q     <= if_req_addr & ~AW'(7);
          wdata_q    <= '0;
          wmask_q    <= '0;
          starve_cnt <= '0;
        end else begin
          owner   <= OWN_LS;
          wen_q   <= ls_req_wen;
          addr_q  <= ls_req_addr & ~AW'(7);
          wdata_q <= ls_req_wdata;
          wmask_q <= ls_req_wmask;
          // Only count LSU wins that actually made the IFU wait.
          if (if_req_valid && (starve_cnt != CW'(STARVE_MAX)))
            starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_mem_arbiter.sv
// Directed plus randomized bench for the memory arbiter, checked against a transaction-level model.
module tb_ysyx_22050598_mem_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_req_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_wen, ls_req_ready, ls_rsp_valid;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
  logic [7:0]  ls_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned model_starve = 0;

  always #5 clk = ~clk;

  ysyx_22050598_mem_arbiter #(
    .AW(64), .DW(64), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_wen(ls_req_wen), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid  = 1'b0; if_req_addr  = '0;
    ls_req_valid  = 1'b0; ls_req_wen   = 1'b0; ls_req_addr = '0;
    ls_req_wdata  = '0;   ls_req_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask

  // One complete transaction starting in IDLE; the winner is predicted from the
  // arbitration rules and the responding port / request fields are checked each cycle.
  task automatic do_txn(input bit ifv, input logic [63:0] ia,
                        input bit lsv, input bit lw, input logic [63:0] la,
                        input logic [63:0] ld, input logic [7:0] lm,
                        input int unsigned rdly, input int unsigned wdly,
                        input logic [63:0] rd, output bit got_ls);
    bit          exp_ls;
    logic [63:0] exp_addr;
    bit          exp_wen;
    logic [7:0]  exp_mask;
    if_req_valid = ifv; if_req_addr = ia;
    ls_req_valid = lsv; ls_req_wen = lw; ls_req_addr = la;
    ls_req_wdata = ld;  ls_req_wmask = lm;
    if (ifv && !lsv)      exp_ls = 1'b0;
    else if (lsv && !ifv) exp_ls = 1'b1;
    else                  exp_ls = (model_starve != STARVE_MAX);
    #1;
    got_ls = ls_req_ready;
    chk("if_req_ready", if_req_ready, !exp_ls);
    chk("ls_req_ready", ls_req_ready, exp_ls);
    chk("idle_busy", busy, 1'b0);
    if (!exp_ls)  model_starve = 0;
    else if (ifv) model_starve = (model_starve < STARVE_MAX) ? model_starve + 1 : STARVE_MAX;
    exp_addr = (exp_ls ? la : ia) & ~64'h7;
    exp_wen  = exp_ls ? lw : 1'b0;
    exp_mask = exp_ls ? lm : 8'h00;
    tick();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    for (int i = 0; i <= int'(rdly); i++) begin
      mem_req_ready = (i == int'(rdly));
      #1;
      chk("mem_req_valid", mem_req_valid, 1'b1);
      chk("mem_req_addr", mem_req_addr, exp_addr);
      chk("mem_req_wen", mem_req_wen, exp_wen);
      chk("mem_req_wmask", mem_req_wmask, exp_mask);
      if (exp_ls) chk("mem_req_wdata", mem_req_wdata, ld);
      chk("req_no_rsp", if_rsp_valid | ls_rsp_valid, 1'b0);
      chk("req_ready_low", if_req_ready | ls_req_ready, 1'b0);
      tick();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < int'(wdly); i++) begin
      #1;
      chk("wait_busy", busy, 1'b1);
      chk("wait_no_mem_req", mem_req_valid, 1'b0);
      chk("wait_no_rsp", if_rsp_valid | ls_rsp_valid, 1'b0);
      tick();
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = rd;
    #1;
    chk("if_rsp_valid", if_rsp_valid, !exp_ls);
    chk("ls_rsp_valid", ls_rsp_valid, exp_ls);
    chk("if_rsp_data", if_rsp_data, exp_ls ? 64'h0 : rd);
    chk("ls_rsp_data", ls_rsp_data, exp_ls ? rd : 64'h0);
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #1;
    chk("done_busy", busy, 1'b0);
    chk("rsp_single_pulse", if_rsp_valid | ls_rsp_valid, 1'b0);
  endtask

  initial begin
    bit          gl;
    logic [5:0]  pattern;
    clear_inputs();

    // Reset held with everything pushing: handshake outputs stay quiet.
    rst = 1'b0;
    if_req_valid = 1'b1; ls_req_valid = 1'b1; mem_rsp_valid = 1'b1;
    tick(); tick();
    chk("rst_if_ready", if_req_ready, 1'b0);
    chk("rst_ls_ready", ls_req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_rsp_valid", if_rsp_valid | ls_rsp_valid, 1'b0);
    chk("rst_mem_req_addr", mem_req_addr, 64'h0);
    chk("rst_starve", dut.starve_cnt, 3'd0);
    clear_inputs();
    rst = 1'b1;
    model_starve = 0;

    // Both valid, LSU streaming reads: LSU x4, IFU, LSU.
    pattern = '0;
    for (int t = 0; t < 6; t++) begin
      do_txn(1'b1, 64'h8000_1000 + 64'(t * 8), 1'b1, 1'b0, 64'h8000_2000 + 64'(t * 8),
             64'h0, 8'h00, 0, 0, 64'hA000 + 64'(t), gl);
      pattern[t] = gl;
      if (t == 4) chk("starve_cleared", dut.starve_cnt, 3'd0);
    end
    chk("grant_pattern", pattern, 6'b101111);

    // IFU-only read with unaligned address.
    do_txn(1'b1, 64'h8000_0004, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 0, 1,
           64'h1122334455667788, gl);

    // LSU write with back-pressure on the memory port.
    do_txn(1'b0, 64'h0, 1'b1, 1'b1, 64'h8000_0010, 64'hDEAD, 8'h03, 3, 1,
           64'h0, gl);

    // Request withdrawn before the edge: no grant taken.
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_0040;
    #1;
    chk("glitch_ready", ls_req_ready, 1'b1);
    ls_req_valid = 1'b0;
    tick();
    chk("glitch_no_accept", busy, 1'b0);

    // Spurious response in IDLE, then a normal fetch.
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBAD0_BAD0;
    #1;
    chk("spurious_no_rsp", if_rsp_valid | ls_rsp_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    chk("spurious_idle", busy, 1'b0);
    do_txn(1'b1, 64'h8000_0100, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1, 0,
           64'hCAFE_F00D_0000_0001, gl);

    // Reset while waiting for the response; a late response must be dropped.
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0200;
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("pre_rst_wait_busy", busy, 1'b1);
    rst = 1'b0; if_req_valid = 1'b1; ls_req_valid = 1'b1;
    tick();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", if_req_ready | ls_req_ready, 1'b0);
    chk("midrst_mem_req_valid", mem_req_valid, 1'b0);
    rst = 1'b1; if_req_valid = 1'b0; ls_req_valid = 1'b0;
    model_starve = 0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h5555;
    #1;
    chk("late_rsp_if", if_rsp_valid, 1'b0);
    chk("late_rsp_ls", ls_rsp_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_idle", busy, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      bit          ifv, lsv;
      int unsigned sel;
      sel = $urandom_range(1, 3);
      ifv = sel[0]; lsv = sel[1];
      if ($urandom_range(0, 3) == 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = {$urandom, $urandom};
        #1;
        chk("rand_spurious", if_rsp_valid | ls_rsp_valid, 1'b0);
        tick();
        mem_rsp_valid = 1'b0;
      end
      do_txn(ifv, {$urandom, $urandom}, lsv, 1'($urandom), {$urandom, $urandom},
             {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), {$urandom, $urandom}, gl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
